aes_wb_ctrl: RTL
================

AES_WB_CTRL -- requirements
Module: aes_wb_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the 256-byte register window.
- TIMEOUT_CYC, 1024, maximum cycles the block waits for the core before flagging an error.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- wb_clk_i, in, 1, the single clock.
- wb_rst_i, in, 1, reset; synchronous, active-high.
- wbs_cyc_i, in, 1, bus cycle.
- wbs_stb_i, in, 1, strobe.
- wbs_we_i, in, 1, write enable.
- wbs_sel_i, in, 4, byte enables.
- wbs_adr_i, in, 32, byte address.
- wbs_dat_i, in, 32, write data.
- wbs_ack_o, out, 1, acknowledge.
- wbs_dat_o, out, 32, read data.
- core_key, out, 128, AES key.
- core_block, out, 128, input block.
- core_encdec, out, 1, 1 = encrypt, 0 = decrypt.
- core_init, out, 1, key-expansion start pulse.
- core_next, out, 1, block start pulse.
- core_ready, in, 1, core idle.
- core_result, in, 128, output block.
- core_result_valid, in, 1, result valid.
- user_irq, out, 1, completion interrupt.

Function
REQ-003 Register map SHALL use offsets from BASE_ADDR:
- 0x00 CTRL: b0 INIT (self-clearing), b1 NEXT (self-clearing), b2 ENCDEC (R/W), b3 IRQ_EN (R/W).
- 0x04 STATUS: b0 BUSY, b1 KEY_VALID, b2 RESULT_VALID, b3 ERR (W1C), b4 IRQ (W1C).
- 0x10–0x1C KEY0..3, with KEY0 = key[127:96].
- 0x20–0x2C BLOCK0..3, same ordering as KEY.
- 0x30–0x3C RESULT0..3, read-only.
REQ-004 Bus handshake: wbs_ack_o SHALL rise exactly one cycle after cyc&stb with an in-window address and no ack currently high; it SHALL stay high for exactly one cycle. Reads SHALL be registered and valid with ack.
REQ-005 Unmapped offsets inside the window SHALL be acked, read as 0 and ignore writes. Addresses outside the window SHALL NOT be acked.
REQ-006 KEY and BLOCK writes SHALL honour wbs_sel_i per byte. CTRL and STATUS writes SHALL take effect only when sel[0] is set.
REQ-007 The FSM SHALL have the states IDLE, WAIT_INIT and WAIT_NEXT.
REQ-008 In IDLE, a CTRL write with INIT=1 SHALL:
- pulse core_init for one cycle;
- clear KEY_VALID;
- move the FSM to WAIT_INIT.
REQ-009 WAIT_INIT SHALL ignore core_ready in its first cycle, then return to IDLE on core_ready=1 and set KEY_VALID.
REQ-010 In IDLE with KEY_VALID=1, a CTRL write with NEXT=1 SHALL:
- pulse core_next for one cycle;
- clear RESULT_VALID;
- move the FSM to WAIT_NEXT.
REQ-011 In WAIT_NEXT, on core_result_valid=1 the block SHALL:
- capture core_result into RESULT0..3;
- set RESULT_VALID;
- set IRQ if IRQ_EN=1;
- return to IDLE.
REQ-012 BUSY SHALL equal (state != IDLE).
REQ-013 INIT and NEXT written together SHALL start INIT only; NEXT is discarded.
REQ-014 NEXT with KEY_VALID=0, or INIT/NEXT while BUSY, SHALL set ERR and SHALL NOT start the core.
REQ-015 KEY/BLOCK writes while BUSY SHALL be acked and discarded. A KEY write in IDLE SHALL clear KEY_VALID.
REQ-016 A cycle counter SHALL run in WAIT_INIT and WAIT_NEXT. On reaching TIMEOUT_CYC the block SHALL set ERR, return to IDLE, and leave KEY_VALID/RESULT_VALID at 0.
REQ-017 user_irq SHALL equal STATUS.IRQ. An IRQ write-1-clear in the same cycle as a set event SHALL leave IRQ=1 (set wins).
REQ-018 core_key, core_block and core_encdec SHALL be driven directly from the registers.

Reset
REQ-019 While wb_rst_i=1 at a clock edge, the block SHALL force:
- wbs_ack_o=0 and wbs_dat_o=0;
- core_init=0 and core_next=0;
- user_irq=0;
- all registers to 0, except ENCDEC=1;
- state to IDLE and the counter to 0.
REQ-020 Reset asserted mid-operation SHALL abort the operation without a result capture, and the first post-reset bus access SHALL be acked normally.

Structure
REQ-021 A package aes_ctrl_pkg SHALL hold the register offsets, the STATUS/CTRL bit positions and the FSM state enum.
REQ-022 Wishbone decode, ack and read mux SHALL live in sub-module aes_ctrl_wb_if. The FSM, counter and registers SHALL live in aes_wb_ctrl.

Verification
REQ-023 The bench SHALL use a behavioural core model (init takes 10 cycles, block takes 20 cycles) and SHALL cover:
- FIPS-197 encrypt: KEY=000102..0f, BLOCK=00112233..ff, INIT, NEXT -> RESULT=69c4e0d86a7b0430d8cdb78070b4c55a, IRQ=1 with IRQ_EN=1.
- NEXT before any INIT -> ERR=1, core_next never pulses, BUSY=0.
- KEY0 write while WAIT_NEXT -> acked, KEY0 unchanged, result still captured.
- Model never asserts ready -> ERR=1 after exactly TIMEOUT_CYC cycles, FSM in IDLE.
- wb_rst_i in WAIT_NEXT, then core_result_valid -> RESULT stays 0, IRQ=0.
- STATUS write 0x10 on the IRQ-set cycle -> IRQ remains 1; read of offset 0x80 -> acked, data 0.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared definitions for the AES Wishbone controller.
//   - register offsets inside the 256-byte window
//   - CTRL / STATUS bit positions
//   - FSM state encoding
//   - helper to pick one 32-bit word out of a 128-bit register (word 0 = MSW)
package aes_ctrl_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_KEY    = 8'h10;
  localparam logic [7:0] OFF_BLOCK  = 8'h20;
  localparam logic [7:0] OFF_RESULT = 8'h30;

  localparam int CTRL_INIT   = 0;
  localparam int CTRL_NEXT   = 1;
  localparam int CTRL_ENCDEC = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY         = 0;
  localparam int STAT_KEY_VALID    = 1;
  localparam int STAT_RESULT_VALID = 2;
  localparam int STAT_ERR          = 3;
  localparam int STAT_IRQ          = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_INIT = 2'd1,
    ST_WAIT_NEXT = 2'd2
  } state_e;

  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

endpackage

// File: rtl/aes_ctrl_wb_if.sv
// aes_ctrl_wb_if: Wishbone slave front end for the AES controller.
// Decodes the 256-byte window at BASE_ADDR, produces a single-cycle ack one
// cycle after the request, registers read data alongside the ack, and hands
// decoded write strobes to the register bank.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   cyc_i..dat_i              Wishbone slave inputs
//   ack_o, dat_o              Wishbone slave outputs
//   ctrl_rd_i..result_i       current register contents for the read mux
//   *_we_o, word_o, sel_o,
//   wdat_o                    decoded write strobes, word index, byte enables, data
module aes_ctrl_wb_if
  import aes_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cyc_i,
  input  logic         stb_i,
  input  logic         we_i,
  input  logic [3:0]   sel_i,
  input  logic [31:0]  adr_i,
  input  logic [31:0]  dat_i,
  output logic         ack_o,
  output logic [31:0]  dat_o,
  input  logic [31:0]  ctrl_rd_i,
  input  logic [31:0]  status_rd_i,
  input  logic [127:0] key_i,
  input  logic [127:0] block_i,
  input  logic [127:0] result_i,
  output logic         ctrl_we_o,
  output logic         status_we_o,
  output logic         key_we_o,
  output logic         block_we_o,
  output logic [1:0]   word_o,
  output logic [3:0]   sel_o,
  output logic [31:0]  wdat_o
);

  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rd_d;
  logic        hit, req, wr;
  logic [7:0]  off;
  logic        aligned;
  logic        is_ctrl, is_status, is_key, is_block, is_result;

  assign off     = adr_i[7:0];
  assign hit     = (adr_i[31:8] == BASE_ADDR[31:8]);
  // A new request is only taken while no ack is outstanding, so a held
  // strobe produces one ack per two cycles.
  assign req     = cyc_i & stb_i & hit & ~ack_q;
  assign wr      = req & we_i;
  // Byte-misaligned addresses fall into the unmapped (read-0) space.
  assign aligned = (off[1:0] == 2'b00);

  assign is_ctrl   = aligned & (off[7:2] == OFF_CTRL[7:2]);
  assign is_status = aligned & (off[7:2] == OFF_STATUS[7:2]);
  assign is_key    = aligned & (off[7:4] == OFF_KEY[7:4]);
  assign is_block  = aligned & (off[7:4] == OFF_BLOCK[7:4]);
  assign is_result = aligned & (off[7:4] == OFF_RESULT[7:4]);

  assign ctrl_we_o   = wr & is_ctrl & sel_i[0];
  assign status_we_o = wr & is_status & sel_i[0];
  assign key_we_o    = wr & is_key;
  assign block_we_o  = wr & is_block;
  assign word_o      = off[3:2];
  assign sel_o       = sel_i;
  assign wdat_o      = dat_i;

  always_comb begin
    rd_d = '0;
    if (is_ctrl)        rd_d = ctrl_rd_i;
    else if (is_status) rd_d = status_rd_i;
    else if (is_key)    rd_d = word_of(key_i, off[3:2]);
    else if (is_block)  rd_d = word_of(block_i, off[3:2]);
    else if (is_result) rd_d = word_of(result_i, off[3:2]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      if (req) dat_q <= we_i ? 32'h0 : rd_d;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/aes_wb_ctrl.sv
// aes_wb_ctrl: Wishbone-controlled sequencer for an external AES core.
// Holds key/block/result registers, CTRL/STATUS, the start/wait FSM and the
// timeout counter; bus decode lives in aes_ctrl_wb_if.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_*                     Wishbone slave
//   core_key/block/encdec     static operands to the core
//   core_init, core_next      one-cycle start pulses
//   core_ready, core_result,
//   core_result_valid         core status and output
//   user_irq                  completion interrupt (STATUS.IRQ)
//
// state        | meaning
// ST_IDLE      | no operation in flight, starts accepted
// ST_WAIT_INIT | key expansion running, core_init pulsed in first cycle
// ST_WAIT_NEXT | block operation running, core_next pulsed in first cycle
module aes_wb_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic [127:0] core_key,
  output logic [127:0] core_block,
  output logic         core_encdec,
  output logic         core_init,
  output logic         core_next,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  input  logic         core_result_valid,
  output logic         user_irq
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               encdec_q, irq_en_q, key_valid_q, result_valid_q, err_q, irq_q;
  logic [127:0]       key_q, block_q, result_q;

  logic               ctrl_we, status_we, key_we, block_we;
  logic [1:0]         word_idx;
  logic [3:0]         wr_sel;
  logic [31:0]        wr_dat;
  logic [31:0]        ctrl_rd, status_rd;
  logic [6:0]         word_base;

  logic busy, first_cyc;
  logic go_init, go_next, start_init, start_next, bad_start;
  logic init_done, next_done, timeout;

  aes_ctrl_wb_if #(.BASE_ADDR(BASE_ADDR)) u_wb_if (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .cyc_i       (wbs_cyc_i),
    .stb_i       (wbs_stb_i),
    .we_i        (wbs_we_i),
    .sel_i       (wbs_sel_i),
    .adr_i       (wbs_adr_i),
    .dat_i       (wbs_dat_i),
    .ack_o       (wbs_ack_o),
    .dat_o       (wbs_dat_o),
    .ctrl_rd_i   (ctrl_rd),
    .status_rd_i (status_rd),
    .key_i       (key_q),
    .block_i     (block_q),
    .result_i    (result_q),
    .ctrl_we_o   (ctrl_we),
    .status_we_o (status_we),
    .key_we_o    (key_we),
    .block_we_o  (block_we),
    .word_o      (word_idx),
    .sel_o       (wr_sel),
    .wdat_o      (wr_dat)
  );

  // Counter is loaded on entry, so the load value marks the first wait cycle.
  // In that cycle core_ready/core_result_valid still reflect the previous
  // operation and are ignored.
  assign first_cyc  = (cnt_q == CNT_LOAD);

  assign go_init    = ctrl_we & wr_dat[CTRL_INIT];
  assign go_next    = ctrl_we & wr_dat[CTRL_NEXT] & ~wr_dat[CTRL_INIT];
  assign start_init = (state_q == ST_IDLE) & go_init;
  assign start_next = (state_q == ST_IDLE) & go_next & key_valid_q;
  assign bad_start  = (go_init | go_next) & ~start_init & ~start_next;

  assign init_done  = (state_q == ST_WAIT_INIT) & ~first_cyc & core_ready;
  assign next_done  = (state_q == ST_WAIT_NEXT) & ~first_cyc & core_result_valid;
  assign timeout    = busy & (cnt_q == '0) & ~init_done & ~next_done;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_init)      state_d = ST_WAIT_INIT;
        else if (start_next) state_d = ST_WAIT_NEXT;
      end
      ST_WAIT_INIT: if (init_done | timeout) state_d = ST_IDLE;
      ST_WAIT_NEXT: if (next_done | timeout) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    core_init = (state_q == ST_WAIT_INIT) & first_cyc;
    core_next = (state_q == ST_WAIT_NEXT) & first_cyc;
  end

  // 3 - word_idx selects the 32-bit slice; KEY0/BLOCK0 is the MSW.
  assign word_base = {~word_idx, 5'b0};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q          <= '0;
      encdec_q       <= 1'b1;
      irq_en_q       <= 1'b0;
      key_valid_q    <= 1'b0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      irq_q          <= 1'b0;
      key_q          <= '0;
      block_q        <= '0;
      result_q       <= '0;
    end else begin
      if (start_init | start_next)     cnt_q <= CNT_LOAD;
      else if (busy && cnt_q != '0)    cnt_q <= cnt_q - CNT_W'(1);

      if (ctrl_we) begin
        encdec_q <= wr_dat[CTRL_ENCDEC];
        irq_en_q <= wr_dat[CTRL_IRQ_EN];
      end

      for (int b = 0; b < 4; b++) begin
        if (key_we && !busy && wr_sel[b])
          key_q[int'(word_base) + 8*b +: 8] <= wr_dat[8*b +: 8];
        if (block_we && !busy && wr_sel[b])
          block_q[int'(word_base) + 8*b +: 8] <= wr_dat[8*b +: 8];
      end

      if (init_done)                           key_valid_q <= 1'b1;
      else if (start_init || (key_we && !busy)) key_valid_q <= 1'b0;

      if (next_done)                    result_valid_q <= 1'b1;
      else if (start_next || timeout)   result_valid_q <= 1'b0;

      if (next_done) result_q <= core_result;

      // Set events take priority over write-1-clear.
      if (bad_start || timeout)                      err_q <= 1'b1;
      else if (status_we && wr_dat[STAT_ERR])        err_q <= 1'b0;

      if (next_done && irq_en_q)                     irq_q <= 1'b1;
      else if (status_we && wr_dat[STAT_IRQ])        irq_q <= 1'b0;
    end
  end

  always_comb begin
    ctrl_rd                    = '0;
    ctrl_rd[CTRL_ENCDEC]       = encdec_q;
    ctrl_rd[CTRL_IRQ_EN]       = irq_en_q;
    status_rd                  = '0;
    status_rd[STAT_BUSY]         = busy;
    status_rd[STAT_KEY_VALID]    = key_valid_q;
    status_rd[STAT_RESULT_VALID] = result_valid_q;
    status_rd[STAT_ERR]          = err_q;
    status_rd[STAT_IRQ]          = irq_q;
  end

  assign core_key    = key_q;
  assign core_block  = block_q;
  assign core_encdec = encdec_q;
  assign user_irq    = irq_q;

endmodule
